// File: rtl/dcoef_collector.sv
// dcoef_collector: re-assembles bit-sliced coefficient lanes into parallel words with a double-buffered output
module dcoef_collector #(
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       dcoef,
    input  logic                   dcoef_sof,
    input  logic                   dcoef_vld,
    output logic                   dcoef_rdy,
    output logic [LANES*DEPTH-1:0] ddata,
    output logic                   ddata_vld,
    input  logic                   ddata_rdy,
    output logic                   sof_err
);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [LANES-1:0][DEPTH-1:0] work, work_n, shifted, load_data;
    logic accept, restart, last, slot_free, load;
    assign dcoef_rdy = state != HOLD;
    assign accept    = dcoef_vld & dcoef_rdy;
    assign slot_free = !ddata_vld | ddata_rdy;
    assign restart   = accept & dcoef_sof & (state == COLLECT);
    assign last      = accept & !restart & (state == COLLECT) & (cnt == CW'(DEPTH - 1));
    // each lane word shifts in its slice bit, MSB first
    always_comb begin
        for (int k = 0; k < LANES; k++) shifted[k] = {work[k][DEPTH-2:0], dcoef[k]};
    end
    // next state: collect slices, hand a complete frame to the output slot or park it in HOLD
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        load      = 1'b0;
        load_data = shifted;
        if (state == HOLD) begin
            load_data = work;
            if (slot_free) begin
                load    = 1'b1;
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else if (accept) begin
            work_n = shifted;
            if (last) begin
                load    = slot_free;
                state_n = slot_free ? IDLE : HOLD;
                cnt_n   = '0;
            end else begin
                state_n = COLLECT;
                cnt_n   = restart ? CW'(1) : cnt + CW'(1);
            end
        end
    end
    // state, work and output registers; a load wins over a clearing transfer on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            ddata     <= '0;
            ddata_vld <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            work    <= work_n;
            sof_err <= restart;
            if (load) begin
                ddata     <= load_data;
                ddata_vld <= 1'b1;
            end else if (ddata_rdy) begin
                ddata_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dcoef_collector.sv
// tb_dcoef_collector: vector table, corner sequences and randomized model check of dcoef_collector
module tb_dcoef_collector;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int W = LANES * DEPTH;
    logic clk = 1'b0;
    logic reset, dcoef_sof, dcoef_vld, dcoef_rdy, ddata_vld, ddata_rdy, sof_err;
    logic [LANES-1:0] dcoef;
    logic [W-1:0] ddata;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic       vld;
        logic       sof;
        logic [3:0] d;
        logic       drdy;
        logic       erdy;
        logic       evld;
        logic [15:0] edata;
        logic       eerr;
    } vec_t;
    vec_t vq[$];

    dcoef_collector #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .dcoef(dcoef), .dcoef_sof(dcoef_sof),
        .dcoef_vld(dcoef_vld), .dcoef_rdy(dcoef_rdy), .ddata(ddata),
        .ddata_vld(ddata_vld), .ddata_rdy(ddata_rdy), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] d, input logic r);
        dcoef_vld = v;
        dcoef_sof = s;
        dcoef = d;
        ddata_rdy = r;
    endtask

    task automatic step(input logic v, input logic s, input logic [3:0] d, input logic r);
        drive(v, s, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic s, input logic [3:0] d, input logic r,
                       input logic erdy, input logic evld, input logic [15:0] edata, input logic eerr);
        vec_t x;
        x.vld = v; x.sof = s; x.d = d; x.drdy = r;
        x.erdy = erdy; x.evld = evld; x.edata = edata; x.eerr = eerr;
        vq.push_back(x);
    endtask

    initial begin
        logic [3:0] part[$];
        logic [15:0] expq[$];
        logic [15:0] w;
        logic err_exp;
        int done, outn, cyc;
        // frame A = 1,2,3,4 -> 016A ; frame B = 8,4,2,1 -> 8421
        add(1,1,4'h1,1, 1,0,16'h0000,0);
        add(1,0,4'h2,1, 1,0,16'h0000,0);
        add(1,0,4'h3,1, 1,0,16'h0000,0);
        add(1,0,4'h4,1, 1,1,16'h016A,0);
        add(1,1,4'h8,1, 1,0,16'h016A,0);
        add(1,0,4'h4,1, 1,0,16'h016A,0);
        add(1,0,4'h2,1, 1,0,16'h016A,0);
        add(1,0,4'h1,1, 1,1,16'h8421,0);
        add(0,0,4'h0,1, 1,0,16'h8421,0);
        add(1,1,4'h1,0, 1,0,16'h8421,0);
        add(1,0,4'h2,0, 1,0,16'h8421,0);
        add(1,0,4'h3,0, 1,0,16'h8421,0);
        add(1,0,4'h4,0, 1,1,16'h016A,0);
        add(1,1,4'h8,0, 1,1,16'h016A,0);
        add(1,0,4'h4,0, 1,1,16'h016A,0);
        add(1,0,4'h2,0, 1,1,16'h016A,0);
        add(1,0,4'h1,0, 1,1,16'h016A,0);
        add(1,1,4'hF,0, 0,1,16'h016A,0);
        add(0,0,4'h0,1, 0,1,16'h8421,0);
        add(0,0,4'h0,0, 1,1,16'h8421,0);
        add(0,0,4'h0,1, 1,0,16'h8421,0);
        add(1,1,4'h9,1, 1,0,16'h8421,0);
        add(1,0,4'h6,1, 1,0,16'h8421,0);
        add(1,1,4'h1,1, 1,0,16'h8421,1);
        add(1,0,4'h2,1, 1,0,16'h8421,0);
        add(1,0,4'h3,1, 1,0,16'h8421,0);
        add(1,0,4'h4,1, 1,1,16'h016A,0);
        add(0,0,4'h0,1, 1,0,16'h016A,0);
        add(1,1,4'h1,1, 1,0,16'h016A,0);
        add(0,1,4'hF,1, 1,0,16'h016A,0);
        add(1,0,4'h2,1, 1,0,16'h016A,0);
        add(1,0,4'h3,1, 1,0,16'h016A,0);
        add(1,0,4'h4,1, 1,1,16'h016A,0);
        reset = 1'b1;
        drive(0, 0, 4'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_rdy", dcoef_rdy, 1);
        chk("reset_vld", ddata_vld, 0);
        chk("reset_data", ddata, 0);
        chk("reset_err", sof_err, 0);
        foreach (vq[i]) begin
            drive(vq[i].vld, vq[i].sof, vq[i].d, vq[i].drdy);
            #4;
            chk($sformatf("vec%0d_rdy", i), dcoef_rdy, vq[i].erdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_vld", i), ddata_vld, vq[i].evld);
            chk($sformatf("vec%0d_data", i), ddata, vq[i].edata);
            chk($sformatf("vec%0d_err", i), sof_err, vq[i].eerr);
        end
        // reset with a held frame and a partial frame in flight
        step(0, 0, 4'h0, 1);
        step(1, 1, 4'h1, 0);
        step(1, 0, 4'h2, 0);
        step(1, 0, 4'h3, 0);
        step(1, 0, 4'h4, 0);
        step(1, 1, 4'h8, 0);
        step(1, 0, 4'h4, 0);
        chk("t5_pre_vld", ddata_vld, 1);
        reset = 1'b1;
        step(0, 0, 4'h0, 0);
        reset = 1'b0;
        chk("t5_data", ddata, 0);
        chk("t5_vld", ddata_vld, 0);
        chk("t5_rdy", dcoef_rdy, 1);
        step(1, 1, 4'h8, 1);
        step(1, 0, 4'h4, 1);
        step(1, 0, 4'h2, 1);
        chk("t5_mid_vld", ddata_vld, 0);
        step(1, 0, 4'h1, 1);
        chk("t5_frame_vld", ddata_vld, 1);
        chk("t5_frame_data", ddata, 16'h8421);
        step(0, 0, 4'h0, 1);
        // randomized traffic against a transposing model
        done = 0; outn = 0; cyc = 0;
        while (done < 200 && cyc < 20000) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
            #4;
            err_exp = 1'b0;
            if (ddata_vld && ddata_rdy) begin
                chk("rand_pending", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    chk("rand_data", ddata, expq.pop_front());
                    outn++;
                end
            end
            if (dcoef_vld && dcoef_rdy) begin
                if (dcoef_sof && part.size() > 0) begin
                    part.delete();
                    err_exp = 1'b1;
                end
                part.push_back(dcoef);
                if (part.size() == DEPTH) begin
                    w = '0;
                    for (int j = 0; j < DEPTH; j++)
                        for (int k = 0; k < LANES; k++)
                            w[k*DEPTH + DEPTH-1-j] = part[j][k];
                    expq.push_back(w);
                    part.delete();
                    done++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            chk("rand_sof_err", sof_err, err_exp);
        end
        chk("rand_frames", done, 200);
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 4'h0, 1);
            #4;
            if (ddata_vld && expq.size() > 0) begin
                chk("drain_data", ddata, expq.pop_front());
                outn++;
            end
            @(posedge clk);
            #1;
        end
        chk("drain_left", expq.size(), 0);
        chk("drain_count", outn, done);
        chk("drain_vld", ddata_vld, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
